// File: rtl/dcache_wb_pkg.sv
// Shared types for the dcache write-back buffer.
//   wb_state_t : drain FSM states
//   wb_entry_t : one buffered victim (line address tag + line data)
//   line_base  : rebuilds a byte address from a stored line tag
package dcache_wb_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [31:OFFSET_W] addr;
    logic [LINE_W-1:0]  line;
  } wb_entry_t;

  function automatic logic [31:0] line_base(input logic [31:OFFSET_W] tag);
    return {tag, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/wb_entry_array.sv
// Register storage for the write-back buffer.
//   clk, rst  : clock, asynchronous active-high reset (clears every entry)
//   we, waddr : tail write port
//   wdata     : entry written at waddr on the clock edge
//   entries   : every entry, read by the top for the head and for forwarding
module wb_entry_array
  import dcache_wb_pkg::*;
#(
  parameter int s_entries = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [s_entries-1:0]              waddr,
  input  wb_entry_t                         wdata,
  output wb_entry_t [(2**s_entries)-1:0]    entries
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     entries        <= '0;
    else if (we) entries[waddr] <= wdata;
  end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the dcache datapath and the cacheline adaptor.
// Dirty victims are pushed in one cycle and drained to pmem in FIFO order.
//   clk, rst                  : clock, asynchronous active-high reset
//   evict_valid/addr/line     : victim push request
//   evict_ready               : push accepted this cycle (buffer not full)
//   wb_empty                  : nothing pending and drain FSM idle
//   pmem_write/address/wdata  : registered write request for the head entry
//   pmem_resp                 : one-cycle completion pulse for the current write
//   lookup_addr, fwd_hit/data : refill forwarding from pending entries
// Build option: DCACHE_WB_FWD_EN compiles in forwarding; otherwise fwd_hit/fwd_data
// are tied to zero and the dcache waits for wb_empty before refilling.
module dcache_wb_buffer
  import dcache_wb_pkg::*;
#(
  parameter int s_entries = 1,
  parameter int s_line    = LINE_W,
  parameter int s_offset  = OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evict_valid,
  input  logic [31:0]       evict_addr,
  input  logic [s_line-1:0] evict_line,
  output logic              evict_ready,
  output logic              wb_empty,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [31:0]       lookup_addr,
  output logic              fwd_hit,
  output logic [s_line-1:0] fwd_data
);

  localparam int DEPTH = 2**s_entries;
  localparam int CW    = s_entries + 1;

  wb_state_t              state, state_next;
  logic [s_entries-1:0]   head, tail;
  logic [CW-1:0]          count, count_next;
  wb_entry_t [DEPTH-1:0]  entries;
  wb_entry_t              push_entry, load_entry;
  logic                   push, pop, load;

  // Ready looks only at the registered count, so a pop in the same cycle
  // never frees a slot for a push.
  assign evict_ready = (count != CW'(DEPTH));
  assign push        = evict_valid & evict_ready;
  assign pop         = (state == WRITE) & pmem_resp;
  assign wb_empty    = (count == '0) & (state == IDLE);

  assign push_entry  = '{addr: evict_addr[31:s_offset], line: evict_line};

  // An empty buffer can only be leaving DONE because of a same-cycle push,
  // whose entry is not in the array yet: take it straight from the inputs.
  assign load_entry  = (count == '0) ? push_entry : entries[head];

  wb_entry_array #(.s_entries(s_entries)) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (push),
    .waddr   (tail),
    .wdata   (push_entry),
    .entries (entries)
  );

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = WRITE;
          load       = 1'b1;
        end
      end
      WRITE: begin
        if (pmem_resp) state_next = DONE;
      end
      DONE: begin
        // count_next includes a push made during DONE itself.
        if (count_next != '0) begin
          state_next = WRITE;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      pmem_write <= (state_next == WRITE);
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      // Request fields are captured once per write and held until pmem_resp.
      if (load) begin
        pmem_address <= line_base(load_entry.addr);
        pmem_wdata   <= load_entry.line;
      end
    end
  end

`ifdef DCACHE_WB_FWD_EN
  // Scan oldest to youngest so the youngest match overrides; a matching
  // same-cycle push is younger still. Entries counted in 'count' are valid,
  // which keeps the head visible through its pop cycle.
  always_comb begin
    logic [s_entries-1:0] idx;
    idx      = head;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + s_entries'(k);
      if ((CW'(k) < count) && (entries[idx].addr == lookup_addr[31:s_offset])) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].line;
      end
    end
    if (push && (evict_addr[31:s_offset] == lookup_addr[31:s_offset])) begin
      fwd_hit  = 1'b1;
      fwd_data = evict_line;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{evict_addr[s_offset-1:0], lookup_addr[s_offset-1:0]};
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;

  logic unused_bits;
  assign unused_bits = ^{evict_addr[s_offset-1:0], lookup_addr};
`endif

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer (default parameters, depth 2).
// Expected pmem writes are queued as pushes are accepted and compared when
// each write request first appears.
module tb_dcache_wb_buffer;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          evict_valid = 1'b0;
  logic [31:0]   evict_addr = '0;
  logic [LW-1:0] evict_line = '0;
  logic          evict_ready, wb_empty, pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp = 1'b0;
  logic [31:0]   lookup_addr = '0;
  logic          fwd_hit;
  logic [LW-1:0] fwd_data;

  always #5 clk = ~clk;

  dcache_wb_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .evict_valid  (evict_valid),
    .evict_addr   (evict_addr),
    .evict_line   (evict_line),
    .evict_ready  (evict_ready),
    .wb_empty     (wb_empty),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .lookup_addr  (lookup_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
  );

  typedef struct {
    logic [31:0]   addr;
    logic [LW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          in_write = 1'b0;
  logic [31:0]   cur_addr = '0;
  logic [LW-1:0] cur_data = '0;

  function automatic logic [LW-1:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  // Advance to the next falling edge and run the write scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (pmem_write && !in_write) begin
      in_write = 1'b1;
      cur_addr = pmem_address;
      cur_data = pmem_wdata;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h", pmem_address);
      end else begin
        e = exp_q.pop_front();
        if (pmem_address !== e.addr || pmem_wdata !== e.data) begin
          errors++;
          $display("FAIL write_order got addr=%h data=%h exp addr=%h data=%h",
                   pmem_address, pmem_wdata, e.addr, e.data);
        end
      end
    end else if (pmem_write) begin
      checks++;
      if (pmem_address !== cur_addr || pmem_wdata !== cur_data) begin
        errors++;
        $display("FAIL write_stable got addr=%h exp addr=%h", pmem_address, cur_addr);
      end
    end else begin
      in_write = 1'b0;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] b, input logic exp_ready);
    exp_t e;
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_line  = fill(b);
    checks++;
    if (evict_ready !== exp_ready) begin
      errors++;
      $display("FAIL push_ready addr=%h got=%b exp=%b", a, evict_ready, exp_ready);
    end
    if (exp_ready) begin
      e.addr = a & 32'hFFFF_FFE0;
      e.data = fill(b);
      exp_q.push_back(e);
    end
    step();
    evict_valid = 1'b0;
  endtask

  task automatic resp_pulse();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(wb_empty && exp_q.size() == 0) && n < 100) begin
      if (pmem_write) resp_pulse();
      else step();
      n++;
    end
    checks++;
    if (!wb_empty || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got wb_empty=%b pending=%0d exp wb_empty=1 pending=0",
               tag, wb_empty, exp_q.size());
    end
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (pmem_write !== 1'b0 || evict_ready !== 1'b1 || wb_empty !== 1'b1 || fwd_hit !== 1'b0 ||
        pmem_address !== 32'h0 || pmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state got write=%b ready=%b empty=%b hit=%b addr=%h exp 0 1 1 0 0",
               pmem_write, evict_ready, wb_empty, fwd_hit, pmem_address);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    push(32'h0000_1000, 8'hAA, 1'b1);
    checks++;
    if (pmem_write !== 1'b0 || wb_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_push_edge got write=%b empty=%b exp 0 0", pmem_write, wb_empty);
    end
    step();
    checks++;
    if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_1000) begin
      errors++;
      $display("FAIL single_write got write=%b addr=%h exp 1 00001000", pmem_write, pmem_address);
    end
    step();
    step();
    resp_pulse();
    checks++;
    if (pmem_write !== 1'b0 || wb_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_done got write=%b empty=%b exp 0 0", pmem_write, wb_empty);
    end
    step();
    checks++;
    if (wb_empty !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_idle got empty=%b pending=%0d exp 1 0", wb_empty, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    push(32'h0000_1000, 8'hA1, 1'b1);
    push(32'h0000_1100, 8'hB2, 1'b1);
    checks++;
    if (evict_ready !== 1'b0 || pmem_write !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full got ready=%b write=%b exp 0 1", evict_ready, pmem_write);
    end
    step();
    resp_pulse();
    checks++;
    if (evict_ready !== 1'b1 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after_pop got ready=%b write=%b exp 1 0", evict_ready, pmem_write);
    end
    step();
    checks++;
    if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_1100) begin
      errors++;
      $display("FAIL b2b_second got write=%b addr=%h exp 1 00001100", pmem_write, pmem_address);
    end
    drain("b2b");
  endtask

  task automatic test_full_resp_push();
    push(32'h0000_3000, 8'h33, 1'b1);
    push(32'h0000_3020, 8'h34, 1'b1);
    step();
    evict_valid = 1'b1;
    evict_addr  = 32'h0000_3040;
    evict_line  = fill(8'h35);
    pmem_resp   = 1'b1;
    checks++;
    if (evict_ready !== 1'b0) begin
      errors++;
      $display("FAIL resp_cycle_ready got=%b exp=0", evict_ready);
    end
    step();
    pmem_resp = 1'b0;
    push(32'h0000_3040, 8'h35, 1'b1);
    checks++;
    if (evict_ready !== 1'b0 || pmem_write !== 1'b1) begin
      errors++;
      $display("FAIL full_refill got ready=%b write=%b exp 0 1", evict_ready, pmem_write);
    end
    drain("full");
  endtask

`ifdef DCACHE_WB_FWD_EN
  task automatic test_fwd();
    exp_t e;
    lookup_addr = 32'h0000_201C;
    push(32'h0000_2000, 8'h11, 1'b1);
    push(32'h0000_2000, 8'h22, 1'b1);
    #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== fill(8'h22)) begin
      errors++;
      $display("FAIL fwd_youngest got hit=%b data=%h exp hit=1 data=%h", fwd_hit, fwd_data, fill(8'h22));
    end
    lookup_addr = 32'h0000_3000;
    #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_miss got hit=%b exp=0", fwd_hit);
    end
    drain("fwd_a");
    push(32'h0000_2000, 8'h11, 1'b1);
    push(32'h0000_2400, 8'h44, 1'b1);
    lookup_addr = 32'h0000_2000;
    pmem_resp   = 1'b1;
    #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== fill(8'h11)) begin
      errors++;
      $display("FAIL fwd_pop_cycle got hit=%b data=%h exp hit=1 data=%h", fwd_hit, fwd_data, fill(8'h11));
    end
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_after_pop got hit=%b exp=0", fwd_hit);
    end
    lookup_addr = 32'h0000_2400;
    evict_valid = 1'b1;
    evict_addr  = 32'h0000_2400;
    evict_line  = fill(8'h55);
    #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== fill(8'h55)) begin
      errors++;
      $display("FAIL fwd_bypass got hit=%b data=%h exp hit=1 data=%h", fwd_hit, fwd_data, fill(8'h55));
    end
    e.addr = 32'h0000_2400;
    e.data = fill(8'h55);
    exp_q.push_back(e);
    step();
    evict_valid = 1'b0;
    drain("fwd_b");
  endtask
`else
  task automatic test_fwd();
    lookup_addr = 32'h0000_2000;
    push(32'h0000_2000, 8'h11, 1'b1);
    #1;
    checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL fwd_disabled got hit=%b data=%h exp hit=0 data=0", fwd_hit, fwd_data);
    end
    drain("fwd_off");
  endtask
`endif

  task automatic test_resp_ignored();
    resp_pulse();
    checks++;
    if (wb_empty !== 1'b1 || evict_ready !== 1'b1 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL resp_idle_empty got empty=%b ready=%b write=%b exp 1 1 0", wb_empty, evict_ready, pmem_write);
    end
    pmem_resp = 1'b1;
    push(32'h0000_4000, 8'h61, 1'b1);
    pmem_resp = 1'b0;
    push(32'h0000_4020, 8'h62, 1'b1);
    checks++;
    if (evict_ready !== 1'b0 || pmem_write !== 1'b1) begin
      errors++;
      $display("FAIL resp_idle_pending got ready=%b write=%b exp 0 1", evict_ready, pmem_write);
    end
    resp_pulse();
    resp_pulse();
    checks++;
    if (pmem_write !== 1'b1 || evict_ready !== 1'b1 || pmem_address !== 32'h0000_4020) begin
      errors++;
      $display("FAIL resp_done got write=%b ready=%b addr=%h exp 1 1 00004020", pmem_write, evict_ready, pmem_address);
    end
    drain("resp_ignored");
  endtask

  task automatic test_reset_mid_write();
    push(32'h0000_5000, 8'h71, 1'b1);
    push(32'h0000_5020, 8'h72, 1'b1);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (pmem_write !== 1'b0 || evict_ready !== 1'b1 || wb_empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got write=%b ready=%b empty=%b exp 0 1 1", pmem_write, evict_ready, wb_empty);
    end
    exp_q.delete();
    in_write = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (pmem_write !== 1'b0 || wb_empty !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cycle=%0d got write=%b empty=%b exp 0 1", i, pmem_write, wb_empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_resp_push();
    test_fwd();
    test_resp_ignored();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
